// File: rtl/tmds_serializer_10to2.sv
// TMDS 10:2 serializer. Accepts one red/green/blue symbol triple per five
// shift-clock cycles and emits each symbol LSB-first as five 2-bit DDR pairs,
// together with the matching TMDS clock-channel pattern. A one-entry holding
// register decouples the source. When no symbol is available, FILL_SYMBOL is
// sent on all three channels and a saturating underflow counter is bumped.
module tmds_serializer_10to2 #(
   parameter logic [9:0] FILL_SYMBOL     = 10'b1101010100,
   parameter int         UNDERFLOW_CNT_W = 16
) (
   input  logic                       clk_shift,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [9:0]                 s_red,
   input  logic [9:0]                 s_green,
   input  logic [9:0]                 s_blue,
   output logic [1:0]                 out_clock,
   output logic [1:0]                 out_red,
   output logic [1:0]                 out_green,
   output logic [1:0]                 out_blue,
   output logic                       underflow,
   output logic [UNDERFLOW_CNT_W-1:0] underflow_count
);

   // Clock channel: five 1s then five 0s on the wire, bit 0 first.
   localparam logic [9:0] CLOCK_SYMBOL = 10'b0000011111;
   localparam logic [2:0] LAST_PHASE   = 3'd4;

   function automatic logic [UNDERFLOW_CNT_W-1:0] sat_inc(
      input logic [UNDERFLOW_CNT_W-1:0] v
   );
      if (&v) return v;
      return v + UNDERFLOW_CNT_W'(1);
   endfunction

   logic [2:0] phase;
   logic       hold_valid;
   logic [9:0] hold_red, hold_green, hold_blue;
   logic [7:0] sr_red, sr_green, sr_blue, sr_clock;

   logic       load;
   logic       xfer;
   logic       bypass;
   logic       capture;
   logic       fill;
   logic [9:0] sym_red, sym_green, sym_blue;

   assign load    = enable && (phase == LAST_PHASE);
   assign s_ready = !hold_valid || load;
   assign xfer    = s_valid && s_ready;
   // A transfer at a load edge with an empty hold goes straight to the
   // shifters; every other transfer lands in the holding register (when the
   // hold is full a transfer is only possible at a load edge, which consumes it).
   assign bypass  = load && !hold_valid && xfer;
   assign capture = xfer && !bypass;
   assign fill    = load && !hold_valid && !xfer;

   assign sym_red   = hold_valid ? hold_red   : (xfer ? s_red   : FILL_SYMBOL);
   assign sym_green = hold_valid ? hold_green : (xfer ? s_green : FILL_SYMBOL);
   assign sym_blue  = hold_valid ? hold_blue  : (xfer ? s_blue  : FILL_SYMBOL);

   // Control: pair phase, hold occupancy and underflow reporting.
   always_ff @(posedge clk_shift or negedge resetn) begin
      if (!resetn) begin
         phase           <= LAST_PHASE;
         hold_valid      <= 1'b0;
         underflow       <= 1'b0;
         underflow_count <= '0;
      end else begin
         if (!enable)
            phase <= LAST_PHASE;
         else if (phase == LAST_PHASE)
            phase <= 3'd0;
         else
            phase <= phase + 3'd1;

         if (capture)
            hold_valid <= 1'b1;
         else if (load && hold_valid)
            hold_valid <= 1'b0;

         underflow <= fill;
         if (fill)
            underflow_count <= sat_inc(underflow_count);
      end
   end

   // Holding register payload; only meaningful while hold_valid is set.
   always_ff @(posedge clk_shift) begin
      if (capture) begin
         hold_red   <= s_red;
         hold_green <= s_green;
         hold_blue  <= s_blue;
      end
   end

   // Serializer: load a whole symbol at the phase-4 edge, shift 2 bits otherwise.
   always_ff @(posedge clk_shift or negedge resetn) begin
      if (!resetn) begin
         out_clock <= 2'b00;
         out_red   <= 2'b00;
         out_green <= 2'b00;
         out_blue  <= 2'b00;
         sr_clock  <= '0;
         sr_red    <= '0;
         sr_green  <= '0;
         sr_blue   <= '0;
      end else if (!enable) begin
         out_clock <= 2'b00;
         out_red   <= 2'b00;
         out_green <= 2'b00;
         out_blue  <= 2'b00;
      end else if (load) begin
         out_clock <= CLOCK_SYMBOL[1:0];
         out_red   <= sym_red[1:0];
         out_green <= sym_green[1:0];
         out_blue  <= sym_blue[1:0];
         sr_clock  <= CLOCK_SYMBOL[9:2];
         sr_red    <= sym_red[9:2];
         sr_green  <= sym_green[9:2];
         sr_blue   <= sym_blue[9:2];
      end else begin
         out_clock <= sr_clock[1:0];
         out_red   <= sr_red[1:0];
         out_green <= sr_green[1:0];
         out_blue  <= sr_blue[1:0];
         sr_clock  <= {2'b00, sr_clock[7:2]};
         sr_red    <= {2'b00, sr_red[7:2]};
         sr_green  <= {2'b00, sr_green[7:2]};
         sr_blue   <= {2'b00, sr_blue[7:2]};
      end
   end

endmodule

// File: tb/tb_tmds_serializer_10to2.sv
// Bench for tmds_serializer_10to2: a table of per-edge vectors for steady
// streaming and fill/underflow behaviour, plus hand sequences for the hold,
// bypass, enable and asynchronous-reset corner cases. A second instance with
// a 2-bit underflow counter shares the stimulus to exercise saturation.
module tb_tmds_serializer_10to2;

   logic       clk_shift = 1'b0;
   logic       resetn    = 1'b0;
   logic       enable    = 1'b0;
   logic       s_valid   = 1'b0;
   logic [9:0] s_red     = '0;
   logic [9:0] s_green   = '0;
   logic [9:0] s_blue    = '0;

   logic        s_ready, underflow;
   logic [1:0]  out_clock, out_red, out_green, out_blue;
   logic [15:0] underflow_count;

   logic        s_ready2, underflow2;
   logic [1:0]  out_clock2, out_red2, out_green2, out_blue2;
   logic [1:0]  underflow_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk_shift = ~clk_shift;

   tmds_serializer_10to2 dut (
      .clk_shift(clk_shift), .resetn(resetn), .enable(enable),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_red(s_red), .s_green(s_green), .s_blue(s_blue),
      .out_clock(out_clock), .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
      .underflow(underflow), .underflow_count(underflow_count)
   );

   tmds_serializer_10to2 #(.UNDERFLOW_CNT_W(2)) dut_w2 (
      .clk_shift(clk_shift), .resetn(resetn), .enable(enable),
      .s_valid(s_valid), .s_ready(s_ready2),
      .s_red(s_red), .s_green(s_green), .s_blue(s_blue),
      .out_clock(out_clock2), .out_red(out_red2), .out_green(out_green2), .out_blue(out_blue2),
      .underflow(underflow2), .underflow_count(underflow_count2)
   );

   typedef struct {
      logic        rst;
      logic        en;
      logic        vld;
      logic [9:0]  r, g, b;
      logic [1:0]  er, eg, eb, ec;
      logic        euf;
      logic        erdy;
      logic [15:0] ecnt;
      logic [1:0]  ecnt2;
   } vec_t;

   vec_t vecs[$];
   vec_t v;

   // Hand-computed pair sequences.
   logic [1:0] clk_pat  [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
   logic [1:0] pat_2ce  [5] = '{2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
   logic [1:0] pat_fill [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_shift);
      #1;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      #2;
      @(negedge clk_shift);
      resetn = 1'b1;
   endtask

   task automatic chk_outs(input string nm, input logic [1:0] r, input logic [1:0] g,
                           input logic [1:0] b, input logic [1:0] c);
      chk({nm, "_red"},    32'(out_red),    32'(r));
      chk({nm, "_green"},  32'(out_green),  32'(g));
      chk({nm, "_blue"},   32'(out_blue),   32'(b));
      chk({nm, "_clock"},  32'(out_clock),  32'(c));
      chk({nm, "_red2"},   32'(out_red2),   32'(r));
      chk({nm, "_clock2"}, 32'(out_clock2), 32'(c));
   endtask

   task automatic chk_pair(input string nm, input int k,
                           input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
      chk_outs($sformatf("%s_p%0d", nm, k), r[2*k +: 2], g[2*k +: 2], b[2*k +: 2], clk_pat[k]);
   endtask

   task automatic run_pairs(input string nm, input int first_k,
                            input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
      for (int k = first_k; k < 5; k++) begin
         step();
         chk_pair(nm, k, r, g, b);
         chk($sformatf("%s_uf%0d", nm, k), 32'(underflow), 32'd0);
      end
   endtask

   initial begin
      logic [9:0] xr, xg, xb, yr, yg, yb, zr, zg, zb, wr, wg, wb;
      xr = 10'h155; xg = 10'h3E0; xb = 10'h2CE;
      yr = 10'h0F0; yg = 10'h333; yb = 10'h2A5;
      zr = 10'h1C7; zg = 10'h38E; zb = 10'h071;
      wr = 10'h249; wg = 10'h092; wb = 10'h36D;

      // Group A: 10'h2CE streamed continuously.
      for (int i = 0; i < 10; i++) begin
         v.rst = (i == 0); v.en = 1'b1; v.vld = 1'b1;
         v.r = 10'h2CE; v.g = 10'h2CE; v.b = 10'h2CE;
         v.er = pat_2ce[i % 5]; v.eg = pat_2ce[i % 5]; v.eb = pat_2ce[i % 5];
         v.ec = clk_pat[i % 5];
         v.euf = 1'b0;
         v.erdy = (i == 0) || (i % 5 == 4);
         v.ecnt = 16'd0; v.ecnt2 = 2'd0;
         vecs.push_back(v);
      end
      // Group B: no symbols at all, six fill windows.
      for (int i = 0; i < 30; i++) begin
         v.rst = (i == 0); v.en = 1'b1; v.vld = 1'b0;
         v.r = 10'h000; v.g = 10'h000; v.b = 10'h000;
         v.er = pat_fill[i % 5]; v.eg = pat_fill[i % 5]; v.eb = pat_fill[i % 5];
         v.ec = clk_pat[i % 5];
         v.euf = (i % 5 == 0);
         v.erdy = 1'b1;
         v.ecnt = 16'(i / 5 + 1);
         v.ecnt2 = (i / 5 + 1 > 3) ? 2'd3 : 2'(i / 5 + 1);
         vecs.push_back(v);
      end

      // Reset state.
      apply_reset();
      chk("rst_out", 32'({out_clock, out_red, out_green, out_blue}), 32'd0);
      chk("rst_uf", 32'(underflow), 32'd0);
      chk("rst_cnt", 32'(underflow_count), 32'd0);
      chk("rst_rdy", 32'(s_ready), 32'd1);

      for (int n = 0; n < vecs.size(); n++) begin
         if (vecs[n].rst) apply_reset();
         enable = vecs[n].en; s_valid = vecs[n].vld;
         s_red = vecs[n].r; s_green = vecs[n].g; s_blue = vecs[n].b;
         step();
         chk_outs($sformatf("vec%0d", n), vecs[n].er, vecs[n].eg, vecs[n].eb, vecs[n].ec);
         chk($sformatf("vec%0d_uf", n), 32'(underflow), 32'(vecs[n].euf));
         chk($sformatf("vec%0d_uf2", n), 32'(underflow2), 32'(vecs[n].euf));
         chk($sformatf("vec%0d_rdy", n), 32'(s_ready), 32'(vecs[n].erdy));
         chk($sformatf("vec%0d_rdy2", n), 32'(s_ready2), 32'(vecs[n].erdy));
         chk($sformatf("vec%0d_cnt", n), 32'(underflow_count), 32'(vecs[n].ecnt));
         chk($sformatf("vec%0d_cnt2", n), 32'(underflow_count2), 32'(vecs[n].ecnt2));
      end

      // Hold full at phase 4 with a new symbol waiting, then bypass on empty hold.
      enable = 1'b0; s_valid = 1'b0;
      apply_reset();
      enable = 1'b1; s_valid = 1'b1; s_red = xr; s_green = xg; s_blue = xb;
      step(); chk_pair("hx", 0, xr, xg, xb); chk("hx_rdy0", 32'(s_ready), 32'd1);
      s_red = yr; s_green = yg; s_blue = yb;
      step(); chk_pair("hx", 1, xr, xg, xb); chk("hx_rdy1", 32'(s_ready), 32'd0);
      s_red = zr; s_green = zg; s_blue = zb;
      step(); chk_pair("hx", 2, xr, xg, xb); chk("hx_rdy2", 32'(s_ready), 32'd0);
      step(); chk_pair("hx", 3, xr, xg, xb); chk("hx_rdy3", 32'(s_ready), 32'd0);
      step(); chk_pair("hx", 4, xr, xg, xb); chk("hx_rdy4", 32'(s_ready), 32'd1);
      step(); chk_pair("hy", 0, yr, yg, yb);
      chk("hy_uf", 32'(underflow), 32'd0);
      chk("hy_rdy0", 32'(s_ready), 32'd0);
      s_valid = 1'b0;
      run_pairs("hy", 1, yr, yg, yb);
      run_pairs("hz", 0, zr, zg, zb);
      chk("bp_rdy", 32'(s_ready), 32'd1);
      s_valid = 1'b1; s_red = wr; s_green = wg; s_blue = wb;
      step(); chk_pair("bw", 0, wr, wg, wb);
      chk("bw_uf", 32'(underflow), 32'd0);
      s_valid = 1'b0;
      run_pairs("bw", 1, wr, wg, wb);
      step(); chk_outs("bw_fill", 2'b00, 2'b00, 2'b00, 2'b11);
      chk("bw_fill_uf", 32'(underflow), 32'd1);
      chk("bw_fill_cnt", 32'(underflow_count), 32'd1);

      // Enable dropped at phase 2 with a symbol held.
      enable = 1'b0;
      apply_reset();
      enable = 1'b1; s_valid = 1'b1; s_red = xr; s_green = xg; s_blue = xb;
      step(); chk_pair("ex", 0, xr, xg, xb);
      s_red = yr; s_green = yg; s_blue = yb;
      step(); chk_pair("ex", 1, xr, xg, xb);
      s_valid = 1'b0;
      step(); chk_pair("ex", 2, xr, xg, xb);
      enable = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         chk_outs($sformatf("eoff%0d", k), 2'b00, 2'b00, 2'b00, 2'b00);
         chk($sformatf("eoff%0d_uf", k), 32'(underflow), 32'd0);
         chk($sformatf("eoff%0d_rdy", k), 32'(s_ready), 32'd0);
      end
      enable = 1'b1;
      run_pairs("ey", 0, yr, yg, yb);
      step(); chk_outs("ey_fill", 2'b00, 2'b00, 2'b00, 2'b11);
      chk("ey_fill_uf", 32'(underflow), 32'd1);
      chk("ey_fill_cnt", 32'(underflow_count), 32'd1);

      // Transfer accepted while disabled, sent on the first enabled edge.
      enable = 1'b0;
      apply_reset();
      s_valid = 1'b1; s_red = zr; s_green = zg; s_blue = zb;
      #1; chk("doff_rdy_pre", 32'(s_ready), 32'd1);
      step(); chk_outs("doff", 2'b00, 2'b00, 2'b00, 2'b00);
      chk("doff_rdy", 32'(s_ready), 32'd0);
      s_valid = 1'b0;
      step(); step();
      chk("doff_cnt", 32'(underflow_count), 32'd0);
      chk("doff_uf", 32'(underflow), 32'd0);
      enable = 1'b1;
      run_pairs("don", 0, zr, zg, zb);

      // Asynchronous reset in the middle of a fill symbol.
      enable = 1'b0;
      apply_reset();
      enable = 1'b1; s_valid = 1'b0;
      step(); step(); step();
      chk("ar_pre_clock", 32'(out_clock), 32'(2'b01));
      chk("ar_pre_red", 32'(out_red), 32'(2'b01));
      chk("ar_pre_cnt", 32'(underflow_count), 32'd1);
      #1 resetn = 1'b0;
      #1;
      chk("ar_out", 32'({out_clock, out_red, out_green, out_blue}), 32'd0);
      chk("ar_cnt", 32'(underflow_count), 32'd0);
      chk("ar_cnt2", 32'(underflow_count2), 32'd0);
      chk("ar_rdy", 32'(s_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
